// File: rtl/mux_8x1_rr_arbiter.sv
// rtl/mux_8x1_rr_arbiter.sv - round-robin 8:1 W-bit mux arbiter with burst limit and valid/ready output
// Optional macro MUX_ARB_FIXED_PRIO_EN: fixed priority (i0 highest) instead of round-robin.
module mux_8x1_rr_arbiter #(
    parameter int W         = 16,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   req,
    input  logic [W-1:0] i7,
    input  logic [W-1:0] i6,
    input  logic [W-1:0] i5,
    input  logic [W-1:0] i4,
    input  logic [W-1:0] i3,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i0,
    input  logic         out_ready,
    output logic [7:0]   grant,
    output logic [2:0]   s,
    output logic         out_valid,
    output logic [W-1:0] out,
    output logic         busy
);
    localparam int            CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [CW-1:0] beats;
    logic [W-1:0]  data [8];
    logic [2:0]    winner;
    logic          transfer;

    always_comb begin
        data[0] = i0;
        data[1] = i1;
        data[2] = i2;
        data[3] = i3;
        data[4] = i4;
        data[5] = i5;
        data[6] = i6;
        data[7] = i7;
    end

    assign out_valid = busy && req[s];
    assign out       = out_valid ? data[s] : '0;
    assign transfer  = out_valid && out_ready;

`ifdef MUX_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (req[k]) winner = 3'(k);
        end
    end
`else
    logic [2:0] last;
    logic [2:0] idx;
    logic       found;

    // Search starts just above the previous winner; k=8 wraps back onto last itself.
    always_comb begin
        winner = 3'd0;
        idx    = 3'd0;
        found  = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = last + 3'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            s     <= '0;
            busy  <= 1'b0;
            beats <= '0;
`ifndef MUX_ARB_FIXED_PRIO_EN
            last  <= 3'd7;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        s     <= winner;
                        grant <= 8'(1) << winner;
                        beats <= '0;
                        busy  <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req[s] || (transfer && beats == LAST_BEAT)) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
`ifndef MUX_ARB_FIXED_PRIO_EN
                        last  <= s;
`endif
                    end else if (transfer) begin
                        beats <= beats + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_8x1_rr_arbiter.sv
// tb/tb_mux_8x1_rr_arbiter.sv - self-checking bench for mux_8x1_rr_arbiter
module tb_mux_8x1_rr_arbiter;
    localparam int W = 16;
`ifdef MUX_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   req, req1;
    logic         out_ready, out_ready1;
    logic [W-1:0] din [8];
    logic [7:0]   grant, grant1;
    logic [2:0]   s, s1;
    logic         out_valid, out_valid1, busy, busy1;
    logic [W-1:0] out, out1;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    mux_8x1_rr_arbiter #(.W(W), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .i7(din[7]), .i6(din[6]), .i5(din[5]), .i4(din[4]),
        .i3(din[3]), .i2(din[2]), .i1(din[1]), .i0(din[0]),
        .out_ready(out_ready), .grant(grant), .s(s),
        .out_valid(out_valid), .out(out), .busy(busy)
    );

    mux_8x1_rr_arbiter #(.W(W), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1),
        .i7(din[7]), .i6(din[6]), .i5(din[5]), .i4(din[4]),
        .i3(din[3]), .i2(din[2]), .i1(din[1]), .i0(din[0]),
        .out_ready(out_ready1), .grant(grant1), .s(s1),
        .out_valid(out_valid1), .out(out1), .busy(busy1)
    );

    function automatic logic [W-1:0] dval(input int k);
        return W'(16'h1111 * (k + 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input int src, input int n);
        for (int b = 0; b < n; b++) exp_q.push_back(src);
    endtask

    // Scoreboard: every accepted beat must match the next expected source and its data.
    always @(negedge clk) begin
        int src;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_beat observed=src%0d expected=none", s);
            end else begin
                src = exp_q.pop_front();
                chk("beat_src", 32'(s), 32'(src));
                chk("beat_data", 32'(out), 32'(dval(src)));
            end
        end
    end

    initial begin
        logic [7:0] eg;
        int         es;
        for (int k = 0; k < 8; k++) din[k] = dval(k);

        // Reset with all requests pending
        rst_n = 1'b0; req = 8'hFF; out_ready = 1'b0; req1 = 8'h00; out_ready1 = 1'b0;
        tick(); tick();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_s", 32'(s), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out", 32'(out), 0);
        chk("rst_grant1", 32'(grant1), 0);
        rst_n = 1'b1;
        tick();
        chk("t1_grant", 32'(grant), 32'h01);
        chk("t1_s", 32'(s), 0);
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_out", 32'(out), 32'(dval(0)));
        chk("t1_busy", 32'(busy), 1);
        req = 8'h00;
        tick();
        chk("t1_release", 32'(grant), 0);

        // req=81, bursts of 4 with a bubble between grants
        rst_n = 1'b0; #1; rst_n = 1'b1;
        req = 8'h81; out_ready = 1'b1;
        push_beats(0, 4);
        push_beats(FIXED ? 0 : 7, 4);
        push_beats(0, 4);
        tick();
        chk("t2_g0_grant", 32'(grant), 32'h01);
        repeat (4) tick();
        chk("t2_bubble0_busy", 32'(busy), 0);
        chk("t2_bubble0_grant", 32'(grant), 0);
        chk("t2_bubble0_valid", 32'(out_valid), 0);
        tick();
        chk("t2_g1_grant", 32'(grant), FIXED ? 32'h01 : 32'h80);
        chk("t2_g1_s", 32'(s), FIXED ? 0 : 7);
        repeat (4) tick();
        chk("t2_bubble1_busy", 32'(busy), 0);
        tick();
        chk("t2_g2_grant", 32'(grant), 32'h01);
        repeat (4) tick();
        chk("t2_bubble2_busy", 32'(busy), 0);
        req = 8'h00;
        chk("t2_beats_done", 32'(exp_q.size()), 0);

        // Back-pressure on source 3 for 10 cycles
        req = 8'h08; out_ready = 1'b0;
        push_beats(3, 4);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("t3_hold_grant", 32'(grant), 32'h08);
            chk("t3_hold_valid", 32'(out_valid), 1);
            chk("t3_hold_out", 32'(out), 32'(dval(3)));
        end
        out_ready = 1'b1;
        repeat (4) tick();
        chk("t3_release_busy", 32'(busy), 0);
        chk("t3_release_grant", 32'(grant), 0);
        chk("t3_beats_done", 32'(exp_q.size()), 0);
        req = 8'h00;

        // Source 5 withdraws after 2 beats; next search starts at 6
        req = 8'h60; out_ready = 1'b1;
        push_beats(5, 2);
        tick();
        chk("t4_s", 32'(s), 5);
        chk("t4_grant", 32'(grant), 32'h20);
        tick(); tick();
        req = 8'h41; out_ready = 1'b0;
        tick();
        chk("t4_abort_grant", 32'(grant), 0);
        chk("t4_abort_busy", 32'(busy), 0);
        chk("t4_abort_valid", 32'(out_valid), 0);
        tick();
        chk("t4_next_s", 32'(s), FIXED ? 0 : 6);
        chk("t4_next_grant", 32'(grant), FIXED ? 32'h01 : 32'h40);
        req = 8'h00;
        tick();
        chk("t4_beats_done", 32'(exp_q.size()), 0);

        // Async reset mid-burst on source 2
        req = 8'h04; out_ready = 1'b1;
        push_beats(2, 1);
        tick();
        chk("t5_s", 32'(s), 2);
        tick();
        rst_n = 1'b0; req = 8'h85; out_ready = 1'b0;
        #1;
        chk("t5_async_grant", 32'(grant), 0);
        chk("t5_async_busy", 32'(busy), 0);
        chk("t5_async_valid", 32'(out_valid), 0);
        chk("t5_async_out", 32'(out), 0);
        chk("t5_async_s", 32'(s), 0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("t5_after_s", 32'(s), 0);
        chk("t5_after_grant", 32'(grant), 32'h01);
        chk("t5_beats_done", 32'(exp_q.size()), 0);
        req = 8'h00;
        tick();

        // MAX_BURST=1: one beat per grant, strict rotation
        req1 = 8'hFF; out_ready1 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            es = FIXED ? 0 : (k % 8);
            eg = 8'd1 << es;
            tick();
            chk("t6_grant", 32'(grant1), 32'(eg));
            chk("t6_s", 32'(s1), 32'(es));
            chk("t6_out", 32'(out1), 32'(dval(es)));
            tick();
            chk("t6_bubble_grant", 32'(grant1), 0);
            chk("t6_bubble_valid", 32'(out_valid1), 0);
        end
        req1 = 8'h00;
        tick();

        chk("final_queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mux_8x1_rr_arbiter.md
Name: mux_8x1_rr_arbiter

Overview:
- Shares one 8:1 W-bit selection path between eight requesters.
- Arbitrates `req[7:0]` round-robin and registers the winning select `s`.
- Presents the selected input on a valid/ready output port.
- Holds a grant for up to MAX_BURST transfers, then hands off.
- Sits between the requester register banks and the single downstream consumer (ALU/bus).

Parameters:
- W, 16, data width of every input and of `out`.
- MAX_BURST, 4, max transfers per grant; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  8  request per source; bit k belongs to input ik
- i7..i0  input  W each  source data; held stable while req[k]=1
- out_ready  input  1  downstream accepts the beat when high with out_valid
- grant  output  8  one-hot registered grant; all-zero when idle
- s  output  3  registered select index of the current grant
- out_valid  output  1  out carries a beat for the granted source
- out  output  W  data of input i[s]; all-zero when out_valid=0
- busy  output  1  high in state GRANT

Behaviour:
- Reset (rst_n low, async) values:
  - state=IDLE, grant=0, s=0, out_valid=0, busy=0.
  - beat counter=0, last-winner pointer=7, so source 0 has top priority after reset.
- States: IDLE, GRANT.
- IDLE:
  - If req≠0, pick the first set bit searching upward from last+1, wrapping 7→0.
  - On that edge: s←winner, grant←one-hot(winner), beat counter←0, go to GRANT.
  - If req=0, stay in IDLE; outputs unchanged.
- Latency: req rises before edge N → grant/out_valid high after edge N (1 cycle).
- GRANT:
  - out_valid = req[s] (combinational from the registered s).
  - out = i[s] when out_valid, else 0.
- Transfer occurs on an edge when out_valid and out_ready are both high; the beat counter increments.
- Release on an edge, with grant→0, last←s, return to IDLE, when either holds:
  - a transfer makes the count reach MAX_BURST;
  - req[s]=0 (requester withdrew or finished).
- Release costs one bubble cycle: the next grant appears no earlier than 1 cycle after release.
- No release while req[s]=1, the count is below MAX_BURST and out_ready=0; the grant persists indefinitely (back-pressure).
- Requests from other sources are ignored during GRANT; they are evaluated only in IDLE.
- A withdrawn request (req[s] falls with no transfer) aborts the grant with zero beats; this is legal, not an error.
- MAX_BURST=1 gives strict alternation between all active requesters.
- Counter width is $clog2(MAX_BURST+1); it never wraps because release happens at MAX_BURST.
- rst_n asserted mid-burst:
  - all outputs go to reset values immediately (async);
  - the partial burst is discarded;
  - the pointer returns to 7.
- grant is always one-hot or zero; s always equals the index of the set grant bit when busy.

Optional Feature:
- MUX_ARB_FIXED_PRIO_EN defined:
  - IDLE always selects the lowest-index set req bit (i0 highest priority).
  - The last-winner pointer is not implemented.
  - Burst limit and handshake are unchanged.
- Not defined: round-robin as above.

Test Plan:
- Reset with req=8'hFF, then release rst_n: after the first edge s=0, grant=8'h01, out=i0.
- req=8'h81, out_ready=1 constant, MAX_BURST=4:
  - 4 beats of i0, then 1 idle cycle, then 4 beats of i7, then i0 again.
  - Under MUX_ARB_FIXED_PRIO_EN, i0 is re-granted every time.
- Single req[3]=1, out_ready=0 for 10 cycles, then 1:
  - out_valid stays high with out=i3 for 10 cycles, grant=8'h08 throughout;
  - then 4 transfers, then release.
- Grant s=5, then req[5] drops after 2 beats: release on the next edge, grant=0, busy=0, and the next arbitration starts from 6.
- rst_n pulsed low mid-burst (beat 2 of 4 on source 2): outputs go to 0 asynchronously; after release, source 0 is favoured (pointer=7).
- MAX_BURST=1, req=8'hFF, out_ready=1:
  - grant order 0,1,2,…,7,0, each grant 1 beat followed by 1 idle cycle;
  - s tracks the grant index.
